psum_reader: RTL
================

Name: psum_reader

Overview:
- Read-side counterpart of the partial-sum store (pStore).
- Accepts one full packed vector of per-node accumulated sums in a single beat and streams it out one node per beat, node 0 first, over a valid/ready interface to the next layer's input stage.
- Optionally applies ReLU (negative to zero) on the outgoing word.
- Sits between pStore's sum vector output and the next-layer consumer.

Parameters:
- NODES, default `RELU_NODES: number of nodes packed in the input vector; must be at least 2.
- W, default `LAYER_1_BIT_WIDTH: per-node word width, two's complement.
- IW, default $clog2(NODES): width of the node index.

Ports:
- clk  in  1  rising-edge clock.
- clr_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort; returns the block to IDLE.
- relu_en  in  1  1 = clamp negative words to 0 on output; sampled per beat.
- load_valid  in  1  sum_in holds a valid vector.
- load_ready  out  1  block can accept a vector this cycle.
- sum_in  in  NODES*W  packed sums; node k occupies [k*W +: W].
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  W  current node word, after ReLU if relu_en=1.
- out_idx  out  IW  index of the node in out_data.
- out_last  out  1  out_data is node NODES-1.
- busy  out  1  high whenever state is SEND.
- frame_cnt  out  16  completed frames; wraps at 16'hFFFF to 0.

Behaviour:
- Reset (clr_n=0, asynchronous): state=IDLE; buffer=0; idx=0; out_valid=0; out_data=0; out_idx=0; out_last=0; busy=0; frame_cnt=0. load_ready=1 once clr_n is deasserted.
- States are IDLE and SEND.
- Load handshake fires when load_valid & load_ready at a clock edge.
- load_ready = (state==IDLE) | (out_valid & out_ready & out_last). Back-to-back frames therefore have zero bubble.
- IDLE, on load handshake: buffer <= sum_in; idx <= 0; go to SEND. out_valid rises in the next cycle, giving 1-cycle latency from load to the first beat.
- Output beat fires when out_valid & out_ready.
- SEND: out_valid=1. out_data = buffer[idx*W +: W], or 0 if relu_en=1 and that word's MSB is 1. out_idx=idx; out_last=(idx==NODES-1).
  - Beat with idx < NODES-1: idx <= idx+1.
  - Beat with idx == NODES-1: frame_cnt <= frame_cnt+1.
    - If a load handshake fires in the same cycle: reload buffer, idx <= 0, stay in SEND.
    - Otherwise: go to IDLE.
- Stall: while out_valid & !out_ready, buffer, idx, out_data, out_idx and out_last hold stable. relu_en may change during a stall and changes out_data combinationally; consumers sample relu_en only on handshake.
- Outputs out_data, out_idx, out_last are combinational from registered state. In IDLE they are 0.
- ReLU passes W-bit signed words unchanged except the clamp. No width growth, no rounding.
- flush (synchronous): state <= IDLE; idx <= 0; the buffer is left unchanged.
  - flush has priority over load and output handshakes in the same cycle.
  - An interrupted frame does not increment frame_cnt.
  - load_ready is forced to 0 during a flush cycle.
- Reset mid-frame: aborts immediately and asynchronously to the reset values above. Any partial frame is lost and is not counted.
- load_valid while in SEND, outside the last-beat handshake: ignored (load_ready=0). The producer must hold the vector.
- sum_in is sampled only on a load handshake.

Decomposition:
- Shared macros stay in GlobalVariables.v: `RELU_NODES, `LAYER_1_BIT_WIDTH, plus a new `PSUM_FRAME_CNT_W (16).
- State encodings are defined as localparams inside the module.
- One natural sub-module, relu_clamp: combinational, parameterised on W, with inputs word and en and output clamped word. It is reusable by the next-layer logic.
- Everything else (FSM, buffer, index counter, frame counter) stays in psum_reader.

Test Plan (NODES=2, W=4):
- Basic: load sum_in=8'b0101_0101, out_ready=1, relu_en=0 -> beats (idx0, 4'b0101, last=0), (idx1, 4'b0101, last=1); first out_valid one cycle after load; frame_cnt=1; back to IDLE.
- Ordering: load 8'b0111_0001 -> beat0 4'b0001, beat1 4'b0111; load_ready=0 during beat0 and =1 during beat1.
- ReLU: load 8'b1001_0011 with relu_en=1 -> 4'b0011 then 4'b0000; same vector with relu_en=0 -> 4'b0011 then 4'b1001.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 3 cycles on beat0 -> out_data=4'b0001 and out_idx=0 stable for all 3 cycles.
  - Then offer a second vector 8'b0010_0011 during the last beat -> accepted in that cycle, no idle cycle between frames, frame_cnt=2 after the second frame.
- Abort: after beat0 of 8'b0111_0001, assert flush -> next cycle IDLE, out_valid=0, frame_cnt unchanged.
  - Repeat the same point with clr_n pulsed low mid-cycle -> outputs drop to 0 asynchronously and frame_cnt=0.

Source files
------------

// File: rtl/psum_reader_pkg.sv
// psum_reader shared definitions.
// Layer sizing defaults, frame counter width and FSM state type.
package psum_reader_pkg;

    localparam int RELU_NODES        = 8;
    localparam int LAYER_1_BIT_WIDTH = 16;
    localparam int PSUM_FRAME_CNT_W  = 16;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/psum_reader_relu.sv
// relu_clamp: combinational ReLU on one signed word.
// Negative words become zero when en is set; otherwise pass through.
module relu_clamp #(
    parameter int W = 16
) (
    input  logic [W-1:0] word,
    input  logic         en,
    output logic [W-1:0] clamped
);

    // clamp on sign bit only, no width change
    always_comb begin
        clamped = word;
        if (en && word[W-1]) begin
            clamped = '0;
        end
    end

endmodule

// File: rtl/psum_reader.sv
// psum_reader: latches a packed vector of node sums in one beat and
// streams it out one node per beat over valid/ready, node 0 first.
module psum_reader
    import psum_reader_pkg::*;
#(
    parameter int NODES = RELU_NODES,
    parameter int W     = LAYER_1_BIT_WIDTH,
    parameter int IW    = $clog2(NODES)
) (
    input  logic                        clk,
    input  logic                        clr_n,
    input  logic                        flush,
    input  logic                        relu_en,
    input  logic                        load_valid,
    output logic                        load_ready,
    input  logic [NODES*W-1:0]          sum_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [W-1:0]                out_data,
    output logic [IW-1:0]               out_idx,
    output logic                        out_last,
    output logic                        busy,
    output logic [PSUM_FRAME_CNT_W-1:0] frame_cnt
);

    localparam logic [IW-1:0] LAST = IW'(NODES - 1);

    state_t               state;
    state_t               state_nx;
    logic [NODES*W-1:0]   buffer;
    logic [IW-1:0]        idx;
    logic [W-1:0]         word;
    logic [W-1:0]         clamped;
    logic                 send;
    logic                 at_last;
    logic                 beat;
    logic                 last_beat;
    logic                 load_fire;

    assign send      = (state == SEND);
    assign at_last   = (idx == LAST);
    assign beat      = send && out_ready;
    assign last_beat = beat && at_last;

    // a new vector is taken when idle or as the final beat leaves
    assign load_ready = !flush && (!send || last_beat);
    assign load_fire  = load_valid && load_ready;

    assign word = buffer[idx*W +: W];

    relu_clamp #(
        .W(W)
    ) u_clamp (
        .word   (word),
        .en     (relu_en),
        .clamped(clamped)
    );

    assign out_valid = send;
    assign busy      = send;
    assign out_data  = send ? clamped : '0;
    assign out_idx   = send ? idx : '0;
    assign out_last  = send && at_last;

    // state register
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // next state: flush wins, last beat returns idle unless reloaded
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (load_fire) begin
                    state_nx = SEND;
                end
            end
            SEND: begin
                if (last_beat && !load_fire) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (flush) begin
            state_nx = IDLE;
        end
    end

    // vector buffer and node index
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            buffer <= '0;
            idx    <= '0;
        end else if (flush) begin
            idx <= '0;
        end else if (load_fire) begin
            buffer <= sum_in;
            idx    <= '0;
        end else if (beat && !at_last) begin
            idx <= idx + IW'(1);
        end
    end

    // completed-frame counter, wraps naturally
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            frame_cnt <= '0;
        end else if (!flush && last_beat) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

endmodule
